// File: rtl/spi_master_fifo_engine.sv
// SPI mode-0 master engine: pops a word from the TX FIFO, shifts it out MSB-first
// while capturing MISO, then pushes the captured word into the RX FIFO.
module spi_master_fifo_engine #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_enable,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   input  logic                  i_tx_empty,
   output logic                  o_tx_rd_en,
   output logic [DATA_WIDTH-1:0] o_rx_data,
   input  logic                  i_rx_full,
   output logic                  o_rx_wr_en,
   output logic                  o_sclk,
   output logic                  o_cs_n,
   output logic                  o_mosi,
   input  logic                  i_miso,
   output logic                  o_busy
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
   localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_PUSH  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [DIV_W-1:0]      r_div;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [GAP_W-1:0]      r_gap_cnt;
   logic [DATA_WIDTH-1:0] r_tx_sh;
   logic [DATA_WIDTH-1:0] r_rx_sh;
   logic [DATA_WIDTH-1:0] r_rx_data;
   logic                  r_sclk;
   logic                  r_cs_n;
   logic                  r_mosi;
   logic                  r_busy;

   logic                  w_div_tc;
   logic                  w_rise;
   logic                  w_fall;
   logic                  w_last_fall;
   logic                  w_gap_done;
   logic [CNT_W-1:0]      w_bit_nxt;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, SCLK edge decode and the two FIFO strobes
   always_comb begin
      w_state_nxt = r_state;
      o_tx_rd_en  = 1'b0;
      o_rx_wr_en  = 1'b0;
      w_rise      = 1'b0;
      w_fall      = 1'b0;
      w_last_fall = 1'b0;
      w_div_tc    = (r_div == DIV_W'(CLK_DIV - 1));
      w_bit_nxt   = r_bit_cnt + CNT_W'(1);
      w_gap_done  = (r_gap_cnt >= GAP_W'(GAP_CYCLES - 1));
      case (r_state)
         ST_IDLE: begin
            if (i_enable && !i_tx_empty) begin
               o_tx_rd_en  = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_div_tc) begin
               w_rise      = !r_sclk;
               w_fall      = r_sclk;
               w_last_fall = r_sclk && (w_bit_nxt == CNT_W'(DATA_WIDTH));
               if (w_last_fall) begin
                  w_state_nxt = ST_PUSH;
               end
            end
         end
         ST_PUSH: begin
            if (!i_rx_full) begin
               o_rx_wr_en = 1'b1;
               // The IDLE cycle before the next pop also keeps cs_n high
               w_state_nxt = (GAP_CYCLES > 1) ? ST_GAP : ST_IDLE;
            end
         end
         ST_GAP: begin
            if (w_gap_done) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // SCLK half-period divider and SCLK itself
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div  <= '0;
         r_sclk <= 1'b0;
      end else if (o_tx_rd_en) begin
         r_div  <= '0;
         r_sclk <= 1'b0;
      end else if (r_state == ST_SHIFT) begin
         if (w_div_tc) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

   // Bit counter and shift registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt <= '0;
         r_tx_sh   <= '0;
         r_rx_sh   <= '0;
      end else if (o_tx_rd_en) begin
         r_bit_cnt <= '0;
         r_tx_sh   <= i_tx_data;
      end else begin
         if (w_rise) begin
            r_rx_sh <= {r_rx_sh[DATA_WIDTH-2:0], i_miso};
         end
         if (w_fall) begin
            r_bit_cnt <= w_bit_nxt;
            if (!w_last_fall) begin
               r_tx_sh <= {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
            end
         end
      end
   end

   // Chip select and MOSI framing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cs_n <= 1'b1;
         r_mosi <= 1'b0;
      end else if (o_tx_rd_en) begin
         r_cs_n <= 1'b0;
         r_mosi <= i_tx_data[DATA_WIDTH-1];
      end else if (w_fall && !w_last_fall) begin
         r_mosi <= r_tx_sh[DATA_WIDTH-2];
      end else if (o_rx_wr_en) begin
         r_cs_n <= 1'b1;
         r_mosi <= 1'b0;
      end
   end

   // Captured word is held from SHIFT exit until the next word completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_data <= '0;
      end else if (w_last_fall) begin
         r_rx_data <= r_rx_sh;
      end
   end

   // Inter-word gap counter; starts at 1 because the IDLE cycle completes the gap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gap_cnt <= '0;
      end else if (o_rx_wr_en) begin
         r_gap_cnt <= GAP_W'(1);
      end else if ((r_state == ST_GAP) && !w_gap_done) begin
         r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt != ST_IDLE);
      end
   end

   assign o_rx_data = r_rx_data;
   assign o_sclk    = r_sclk;
   assign o_cs_n    = r_cs_n;
   assign o_mosi    = r_mosi;
   assign o_busy    = r_busy;

endmodule
